// File: rtl/list_range_source_if.sv
// list_range_source_if
//   Request/acknowledge list stream between a list consumer (master) and a
//   list producer (slave).
//   ready       consumer -> producer  arguments valid, list active (level)
//   first/last  consumer -> producer  inclusive range, sampled when a list opens
//   step        consumer -> producer  increment, 0 is treated as 1
//   req         consumer -> producer  request next element (level)
//   done        producer -> consumer  list handle available
//   ack         producer -> consumer  one-cycle pulse, value/value_valid meaningful
//   value       producer -> consumer  element, 0 at end of list
//   value_valid producer -> consumer  1 = element, 0 = end of list
interface list_range_source_if #(
  parameter int WIDTH = 8
) ();
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] first;
  logic [WIDTH-1:0] last;
  logic [WIDTH-1:0] step;
  logic             req;
  logic             ack;
  logic [WIDTH-1:0] value;
  logic             value_valid;

  modport master (
    output ready, first, last, step, req,
    input  done, ack, value, value_valid
  );

  modport slave (
    input  ready, first, last, step, req,
    output done, ack, value, value_valid
  );
endinterface

// File: rtl/list_range_source.sv
// list_range_source
//   Producer end of the list req/ack stream. Yields first, first+step, ...
//   up to and including last, one element per request, then end-of-list
//   (value_valid=0, value=0) on every later request.
//   clock  in  system clock, posedge
//   reset  in  synchronous, active-high
//   bus    list stream, slave side (see list_range_source_if)
//   WIDTH   element width
//   LATENCY extra cycles between sampling req high and asserting ack
module list_range_source #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2
) (
  input logic                clock,
  input logic                reset,
  list_range_source_if.slave bus
);

  localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_WORK     = 3'd2,
    S_ACK      = 3'd3,
    S_WAIT_LOW = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic             empty_q, empty_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             ack_q, ack_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             vv_q, vv_d;
  logic [WIDTH:0]   sum_s;

  // Next-state and next-output computation for the list producer.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    step_d  = step_q;
    empty_d = empty_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    value_d = value_q;
    vv_d    = vv_q;
    // Extra carry bit so an overflowing increment ends the list instead of wrapping.
    sum_s   = {1'b0, cur_q} + {1'b0, step_q};

    if (!bus.ready) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          cur_d   = bus.first;
          last_d  = bus.last;
          step_d  = (bus.step == {WIDTH{1'b0}}) ? {{(WIDTH-1){1'b0}}, 1'b1} : bus.step;
          empty_d = (bus.first > bus.last);
          state_d = S_ARMED;
        end
        S_ARMED: begin
          if (bus.req) begin
            if (LATENCY == 0) begin
              state_d = S_ACK;
            end else begin
              cnt_d   = CW'(LATENCY);
              state_d = S_WORK;
            end
          end else begin
            state_d = S_ARMED;
          end
        end
        S_WORK: begin
          // Dropping req abandons the request without consuming an element.
          if (!bus.req) begin
            state_d = S_ARMED;
          end else if (cnt_q == CW'(1)) begin
            state_d = S_ACK;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_ACK: begin
          ack_d   = 1'b1;
          state_d = S_WAIT_LOW;
          if (empty_q) begin
            value_d = {WIDTH{1'b0}};
            vv_d    = 1'b0;
          end else begin
            value_d = cur_q;
            vv_d    = 1'b1;
            empty_d = sum_s[WIDTH] | (sum_s[WIDTH-1:0] > last_q);
            cur_d   = sum_s[WIDTH-1:0];
          end
        end
        S_WAIT_LOW: begin
          // A held req is acked only once; wait for it to drop.
          if (!bus.req) begin
            state_d = S_ARMED;
          end else begin
            state_d = S_WAIT_LOW;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    done_d = (state_d != S_IDLE);
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cur_q   <= {WIDTH{1'b0}};
      last_q  <= {WIDTH{1'b0}};
      step_q  <= {WIDTH{1'b0}};
      empty_q <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      value_q <= {WIDTH{1'b0}};
      vv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      step_q  <= step_d;
      empty_q <= empty_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      value_q <= value_d;
      vv_q    <= vv_d;
    end
  end

  assign bus.done        = done_q;
  assign bus.ack         = ack_q;
  assign bus.value       = value_q;
  assign bus.value_valid = vv_q;

endmodule

// File: tb/tb_list_range_source.sv
module tb_list_range_source;

  typedef struct {
    logic [7:0] v;
    logic       vv;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];

  list_range_source_if #(.WIDTH(8)) ifa ();
  list_range_source_if #(.WIDTH(8)) ifb ();

  list_range_source #(.WIDTH(8), .LATENCY(2)) dut_a (
    .clock (clk),
    .reset (rst),
    .bus   (ifa)
  );

  list_range_source #(.WIDTH(8), .LATENCY(0)) dut_b (
    .clock (clk),
    .reset (rst),
    .bus   (ifb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, req_v);
    end
  endtask

  // Scoreboard monitor: every ack is compared with the oldest expected element.
  task automatic monitor();
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (ifa.ack === 1'b1) begin
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL a_ack unexpected ack got value=%0d vv=%0d required no ack", ifa.value, ifa.value_valid);
        end else begin
          e = qa.pop_front();
          if (ifa.value !== e.v || ifa.value_valid !== e.vv || cyc != e.cyc) begin
            errors++;
            $display("FAIL a_ack got value=%0d vv=%0d cycle=%0d required value=%0d vv=%0d cycle=%0d",
                     ifa.value, ifa.value_valid, cyc, e.v, e.vv, e.cyc);
          end
        end
      end
      if (ifb.ack === 1'b1) begin
        checks++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL b_ack unexpected ack got value=%0d vv=%0d required no ack", ifb.value, ifb.value_valid);
        end else begin
          e = qb.pop_front();
          if (ifb.value !== e.v || ifb.value_valid !== e.vv || cyc != e.cyc) begin
            errors++;
            $display("FAIL b_ack got value=%0d vv=%0d cycle=%0d required value=%0d vv=%0d cycle=%0d",
                     ifb.value, ifb.value_valid, cyc, e.v, e.vv, e.cyc);
          end
        end
      end
    end
  endtask

  // Open a new list on dut sel (0 = LATENCY 2, 1 = LATENCY 0).
  task automatic start(input int sel, input logic [7:0] f, input logic [7:0] l, input logic [7:0] s);
    @(negedge clk);
    if (sel == 0) ifa.ready = 1'b0; else ifb.ready = 1'b0;
    @(negedge clk);
    if (sel == 0) begin
      ifa.first = f; ifa.last = l; ifa.step = s; ifa.ready = 1'b1;
    end else begin
      ifb.first = f; ifb.last = l; ifb.step = s; ifb.ready = 1'b1;
    end
    @(negedge clk);
    if (sel == 0) check("done_a", ifa.done, 1); else check("done_b", ifb.done, 1);
  endtask

  // One request: ack is expected LATENCY+1 edges after the edge that samples req.
  task automatic request(input int sel, input logic [7:0] v, input logic vv);
    exp_t e;
    @(negedge clk);
    e.v = v;
    e.vv = vv;
    if (sel == 0) begin
      e.cyc = cyc + 4;
      qa.push_back(e);
      ifa.req = 1'b1;
    end else begin
      e.cyc = cyc + 2;
      qb.push_back(e);
      ifb.req = 1'b1;
    end
    repeat (6) @(negedge clk);
    if (sel == 0) ifa.req = 1'b0; else ifb.req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    ifa.ready = 1'b0; ifa.req = 1'b0; ifa.first = 8'd0; ifa.last = 8'd0; ifa.step = 8'd0;
    ifb.ready = 1'b0; ifb.req = 1'b0; ifb.first = 8'd0; ifb.last = 8'd0; ifb.step = 8'd0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack_a", ifa.ack, 0);
    check("rst_done_a", ifa.done, 0);
    check("rst_value_a", ifa.value, 0);
    check("rst_vv_a", ifa.value_valid, 0);
    check("rst_ack_b", ifb.ack, 0);
    check("rst_done_b", ifb.done, 0);
    rst = 1'b0;

    // Basic list 1..2 then sticky end
    start(0, 8'd1, 8'd2, 8'd1);
    request(0, 8'd1, 1'b1);
    request(0, 8'd2, 1'b1);
    request(0, 8'd0, 1'b0);
    request(0, 8'd0, 1'b0);

    // Empty list
    start(0, 8'd5, 8'd4, 8'd1);
    request(0, 8'd0, 1'b0);

    // Overflow ends list without wrapping
    start(0, 8'd250, 8'd255, 8'd4);
    request(0, 8'd250, 1'b1);
    request(0, 8'd254, 1'b1);
    request(0, 8'd0, 1'b0);

    // step 0 behaves as 1
    start(0, 8'd3, 8'd4, 8'd0);
    request(0, 8'd3, 1'b1);
    request(0, 8'd4, 1'b1);
    request(0, 8'd0, 1'b0);

    // Held req acked once; abandoned request consumes nothing
    start(0, 8'd10, 8'd20, 8'd5);
    request(0, 8'd10, 1'b1);
    @(negedge clk);
    e.v = 8'd15; e.vv = 1'b1; e.cyc = cyc + 4;
    qa.push_back(e);
    ifa.req = 1'b1;
    repeat (14) @(negedge clk);
    ifa.req = 1'b0;
    @(negedge clk);
    ifa.req = 1'b1;
    @(negedge clk);
    ifa.req = 1'b0;
    repeat (4) @(negedge clk);
    request(0, 8'd20, 1'b1);
    repeat (3) @(negedge clk);
    check("hold_value_a", ifa.value, 20);
    check("hold_vv_a", ifa.value_valid, 1);

    // Reset mid-WORK
    start(0, 8'd7, 8'd9, 8'd1);
    ifa.req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ack_a", ifa.ack, 0);
    check("mid_rst_done_a", ifa.done, 0);
    check("mid_rst_value_a", ifa.value, 0);
    check("mid_rst_vv_a", ifa.value_valid, 0);
    rst = 1'b0;
    ifa.req = 1'b0;
    ifa.ready = 1'b0;
    repeat (5) @(negedge clk);

    // ready dropped mid-list restarts from first
    start(0, 8'd1, 8'd9, 8'd2);
    request(0, 8'd1, 1'b1);
    request(0, 8'd3, 1'b1);
    ifa.ready = 1'b0;
    @(negedge clk);
    check("drop_done_a", ifa.done, 0);
    ifa.ready = 1'b1;
    @(negedge clk);
    check("reraise_done_a", ifa.done, 1);
    request(0, 8'd1, 1'b1);

    // Zero-latency instance
    start(1, 8'd7, 8'd8, 8'd1);
    request(1, 8'd7, 1'b1);
    request(1, 8'd8, 1'b1);
    request(1, 8'd0, 1'b0);

    // All expected acks must have arrived
    repeat (10) @(negedge clk);
    check("missing_acks_a", qa.size(), 0);
    check("missing_acks_b", qb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
